// File: rtl/cesa_checker.sv
// -----------------------------------------------------------------------------
// cesa_checker
//
// Checker/corrector for the carry-speculative adder datapath. A request carries
// two operands, a carry-in and the speculated carry-out of every BLOCK_W-bit
// block. The checker walks the exact carry chain one block per cycle, records
// which speculated block carries were wrong, and returns the exact sum and
// carry-out over a valid/ready handshake. A saturating counter tracks how many
// delivered results contained at least one mis-speculation.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   in_valid_i    request valid
//   in_ready_o    request accepted when high with in_valid_i (IDLE only)
//   a_i, b_i      W-bit unsigned operands (W = BLOCKS*BLOCK_W)
//   cin_i         carry into block 0
//   spec_carry_i  speculated carry-out of block k at bit k
//   out_valid_o   result valid (DONE only)
//   out_ready_i   result consumed when high with out_valid_o
//   sum_o         exact sum a+b+cin modulo 2^W
//   cout_o        exact carry-out
//   err_mask_o    bit k set: speculated carry of block k was wrong
//   err_o         OR of err_mask_o
//   err_count_o   saturating count of delivered results with err_o=1
// -----------------------------------------------------------------------------
module cesa_checker #(
    parameter int BLOCKS  = 4,
    parameter int BLOCK_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [BLOCKS*BLOCK_W-1:0]  a_i,
    input  logic [BLOCKS*BLOCK_W-1:0]  b_i,
    input  logic                       cin_i,
    input  logic [BLOCKS-1:0]          spec_carry_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [BLOCKS*BLOCK_W-1:0]  sum_o,
    output logic                       cout_o,
    output logic [BLOCKS-1:0]          err_mask_o,
    output logic                       err_o,
    output logic [CNT_W-1:0]           err_count_o
);

    localparam int W   = BLOCKS * BLOCK_W;
    localparam int K_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(BLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Captured request
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [BLOCKS-1:0] spec_q;

    // Walk state and result registers
    logic              c;
    logic [K_W-1:0]    k;
    logic [W-1:0]      sum;
    logic              cout;
    logic [BLOCKS-1:0] err_mask;
    logic [CNT_W-1:0]  err_count;

    // Block adder for the current index
    logic [BLOCK_W-1:0] a_blk;
    logic [BLOCK_W-1:0] b_blk;
    logic [BLOCK_W:0]   blk_sum;
    logic               blk_cy;

    logic accept;
    logic deliver;
    logic last_blk;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    assign accept   = (state == IDLE) && in_valid_i;
    assign deliver  = (state == DONE) && out_ready_i;
    assign last_blk = (k == K_LAST);

    always_comb begin
        a_blk   = a_q[k*BLOCK_W +: BLOCK_W];
        b_blk   = b_q[k*BLOCK_W +: BLOCK_W];
        blk_sum = {1'b0, a_blk} + {1'b0, b_blk} + {{BLOCK_W{1'b0}}, c};
        blk_cy  = blk_sum[BLOCK_W];
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid_i)  state_next = WALK;
            WALK:    if (last_blk)    state_next = DONE;
            DONE:    if (out_ready_i) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // ---- FSM: outputs, decoded from the state register only ----
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            IDLE:    in_ready_o  = 1'b1;
            DONE:    out_valid_o = 1'b1;
            default: ;
        endcase
    end

    // ---- Capture and carry walk ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q      <= '0;
            b_q      <= '0;
            spec_q   <= '0;
            c        <= 1'b0;
            k        <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            err_mask <= '0;
        end else if (accept) begin
            a_q      <= a_i;
            b_q      <= b_i;
            spec_q   <= spec_carry_i;
            c        <= cin_i;
            k        <= '0;
            sum      <= '0;
            err_mask <= '0;
        end else if (state == WALK) begin
            sum[k*BLOCK_W +: BLOCK_W] <= blk_sum[BLOCK_W-1:0];
            err_mask[k]               <= (blk_cy != spec_q[k]);
            // The exact carry, not the speculated one, feeds the next block.
            c <= blk_cy;
            k <= k + 1'b1;
            if (last_blk) begin
                cout <= blk_cy;
            end
        end
    end

    // ---- Error counter, stepped only on delivery ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_count <= '0;
        end else if (deliver && (|err_mask)) begin
            err_count <= sat_inc(err_count);
        end
    end

    assign sum_o       = sum;
    assign cout_o      = cout;
    assign err_mask_o  = err_mask;
    assign err_o       = |err_mask;
    assign err_count_o = err_count;

endmodule

// File: tb/tb_cesa_checker.sv
module tb_cesa_checker;

    localparam int BLOCKS  = 4;
    localparam int BLOCK_W = 8;
    localparam int CNT_W   = 2;
    localparam int W       = BLOCKS * BLOCK_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      a_in = '0;
    logic [W-1:0]      b_in = '0;
    logic              cin = 1'b0;
    logic [BLOCKS-1:0] spec = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      sum;
    logic              cout;
    logic [BLOCKS-1:0] err_mask;
    logic              err;
    logic [CNT_W-1:0]  err_count;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    cesa_checker #(
        .BLOCKS (BLOCKS),
        .BLOCK_W(BLOCK_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .cin_i       (cin),
        .spec_carry_i(spec),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .err_mask_o  (err_mask),
        .err_o       (err),
        .err_count_o (err_count)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word addition in wide integer arithmetic.
    function automatic longint unsigned ref_total(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic ci);
        longint unsigned la = 64'(a);
        longint unsigned lb = 64'(b);
        return la + lb + 64'(ci);
    endfunction

    // Reference: true carry out of block k is the carry out of adding the low
    // (k+1)*BLOCK_W bits of the operands with cin.
    function automatic logic [BLOCKS-1:0] ref_mask(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input logic ci, input logic [BLOCKS-1:0] sp);
        logic [BLOCKS-1:0] m;
        for (int k = 0; k < BLOCKS; k++) begin
            longint unsigned msk = (64'd1 << (BLOCK_W * (k + 1))) - 64'd1;
            longint unsigned s = (64'(a) & msk) + (64'(b) & msk) + 64'(ci);
            longint unsigned cy = (s >> (BLOCK_W * (k + 1))) & 64'd1;
            m[k] = (cy[0] != sp[k]);
        end
        return m;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [BLOCKS-1:0] sp, input int hold);
        longint unsigned tot = ref_total(a, b, ci);
        logic [W-1:0]      e_sum  = tot[W-1:0];
        logic              e_cout = tot[W];
        logic [BLOCKS-1:0] e_mask = ref_mask(a, b, ci, sp);

        chk("ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; a_in = a; b_in = b; cin = ci; spec = sp;
        step();
        // Scramble inputs: they must be ignored after acceptance.
        in_valid = 1'b0;
        a_in = $urandom; b_in = $urandom; cin = 1'($urandom); spec = BLOCKS'($urandom);
        for (int i = 0; i < BLOCKS; i++) begin
            chk("walk_no_valid", 64'(out_valid), 64'd0);
            chk("walk_not_ready", 64'(in_ready), 64'd0);
            step();
        end
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("sum", 64'(sum), 64'(e_sum));
        chk("cout", 64'(cout), 64'(e_cout));
        chk("err_mask", 64'(err_mask), 64'(e_mask));
        chk("err", 64'(err), 64'(|e_mask));
        chk("count_pre", 64'(err_count), 64'(exp_cnt));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            a_in = $urandom;
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_not_ready", 64'(in_ready), 64'd0);
            chk("hold_sum", 64'(sum), 64'(e_sum));
            chk("hold_cout", 64'(cout), 64'(e_cout));
            chk("hold_mask", 64'(err_mask), 64'(e_mask));
            chk("hold_count", 64'(err_count), 64'(exp_cnt));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if ((|e_mask) && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
        chk("post_no_valid", 64'(out_valid), 64'd0);
        chk("post_ready", 64'(in_ready), 64'd1);
        chk("count_post", 64'(err_count), 64'(exp_cnt));
        chk("idle_sum_kept", 64'(sum), 64'(e_sum));
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_mask", 64'(err_mask), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_count", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        step();

        // Directed cases
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 4'b0000, 0);
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 4'b0000, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'b1111, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'b0000, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b1010, 3);

        // Reset after the edge that processes block 1
        in_valid = 1'b1; a_in = 32'h00FF_00FF; b_in = 32'h0001_0001; cin = 1'b0; spec = 4'b0000;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_count", 64'(err_count), 64'd0);
        chk("mid_rst_mask", 64'(err_mask), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 4'b0000, 0);

        // Saturation: five error results on a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 4'b0000, i % 2);
        end
        chk("sat_final", 64'(err_count), 64'd3);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0]      ra = $urandom;
            logic [W-1:0]      rb = $urandom;
            logic              rc = 1'($urandom);
            logic [BLOCKS-1:0] rs = BLOCKS'($urandom);
            if (i % 4 == 0) ra = 32'hFFFF_FFFF ^ rb;
            run_op(ra, rb, rc, rs, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cesa_checker.md
# cesa_checker

Sequential checker and corrector for the carry-speculative adder (CESA) datapath. Each 8-bit CESA block speculates its carry-out from its upper four bit pairs rather than waiting for the ripple. This block receives the operands together with the speculated block-boundary carries. It re-derives the exact carry chain one block per cycle, flags every boundary where the speculation was wrong, and returns the exact sum and carry-out over a valid/ready handshake. It sits behind the speculative adder in the ALU error-recovery path.

## Interface
Parameters:
- BLOCKS, default 4: number of CESA blocks; operand width W = BLOCKS*BLOCK_W.
- BLOCK_W, default 8: bits per block.
- CNT_W, default 16: width of the saturating error counter.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  request accepted when high together with in_valid_i.
- a_i  input  W  operand A.
- b_i  input  W  operand B.
- cin_i  input  1  carry into block 0.
- spec_carry_i  input  BLOCKS  speculated carry-out of block k at bit k. Bit BLOCKS-1 is the speculated final carry-out.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  result consumed when high together with out_valid_o.
- sum_o  output  W  exact sum a+b+cin, modulo 2^W.
- cout_o  output  1  exact carry-out.
- err_mask_o  output  BLOCKS  bit k set means the speculated carry-out of block k differed from the exact carry.
- err_o  output  1  OR-reduction of err_mask_o.
- err_count_o  output  CNT_W  count of delivered results with err_o=1, saturating at all-ones.

## Operation
- FSM states: IDLE, WALK, DONE. Reset state is IDLE.
- IDLE: in_ready_o=1. On in_valid_i&&in_ready_o:
  - capture a_i, b_i and spec_carry_i;
  - load the carry register c with cin_i;
  - clear the block index k, the sum register and err_mask;
  - go to WALK.
- WALK: each cycle processes block k:
  - compute {cy, s} = a[k] + b[k] + c, where a[k] and b[k] are the BLOCK_W-bit slices;
  - write s into sum bits [k*BLOCK_W +: BLOCK_W];
  - set err_mask[k] = (cy != spec_carry[k]);
  - c <= cy. The exact carry, never the speculated one, propagates to the next block.
  - k increments. After processing k=BLOCKS-1: cout <= cy, go to DONE.
- DONE: out_valid_o=1. All result outputs are held stable until out_valid_o&&out_ready_i.
  - On that handshake: err_count increments if err_o=1 and the counter is not saturated; go to IDLE.
- in_ready_o=0 in WALK and DONE. A request cannot be accepted in the same cycle as a result handshake.
- Inputs are ignored except on the acceptance edge. Changing a_i, b_i or spec_carry_i during WALK has no effect.
- Arithmetic: unsigned, W bits. Overflow is reported only through cout_o.
- err_count_o saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset (asynchronous, any state, including mid-WALK):
  - state=IDLE, out_valid_o=0, in_ready_o=1;
  - sum_o=0, cout_o=0, err_mask_o=0, err_o=0, err_count_o=0.
  - Any in-flight operation is discarded.
- in_ready_o and out_valid_o decode the state register directly; there is no combinational path from inputs to outputs.
- Latency: if the request is accepted at edge E0, blocks 0..BLOCKS-1 are processed at edges E1..E_BLOCKS, and out_valid_o is high from edge E_BLOCKS onward. The default is 4 cycles.
- With out_ready_i held high, DONE lasts exactly one cycle. in_ready_o is high the cycle after the result handshake. Minimum initiation interval is BLOCKS+2 cycles.
- Backpressure: out_ready_i low holds DONE indefinitely. sum_o, cout_o, err_mask_o, err_o and err_count_o are unchanged while held.
- sum_o, cout_o and err_mask_o are valid only while out_valid_o=1. They keep their last values in IDLE and change during WALK.

## Test plan
- Clean add: a=0x12345678, b=0x11111111, cin=0, spec=4'b0000 -> out_valid 4 cycles after accept, sum=0x23456789, cout=0, err_mask=0000, err_count unchanged.
- Single mis-speculation: a=0x000000FF, b=0x00000001, cin=0, spec=4'b0000 -> sum=0x00000100, cout=0, err_mask=0001, err_o=1; err_count goes 0 to 1 on the handshake.
- Full ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0, cout=1. With spec=4'b1111: err_mask=0000. Repeated with spec=4'b0000: err_mask=1111.
- Backpressure: hold out_ready_i=0 for 3 cycles in DONE and drive new in_valid_i=1 -> outputs stable, in_ready_o=0, no second accept. Release -> in_ready_o=1 the next cycle.
- Reset mid-operation: assert rst_ni low after the edge that processes block 1 -> out_valid_o=0, in_ready_o=1 and err_count_o=0 immediately. The next request completes normally.
- Saturation (CNT_W=2): five consecutive error results (case 2) -> err_count_o goes 1,2,3,3,3.
